// File: rtl/qe_signal_emulator.sv
// -----------------------------------------------------------------------------
// qe_signal_emulator
//
// Generates quadrature encoder signals (A, B, I) from a commanded signed edge
// count at a programmable rate. Used as a stand-in motor encoder for driving
// QE decoder channels and external stepper/encoder interfaces.
//
// Ports
//   clk             system clock, all logic on the rising edge
//   reset           synchronous, active-high
//   cmd_valid       command present
//   cmd_ready       command accepted on a cycle with cmd_valid & cmd_ready
//   cmd_steps       signed edge count (>0 CW, <0 CCW)
//   cmd_phase_time  clk cycles per quadrature phase (0 behaves as 1)
//   abort           stop motion immediately and return to IDLE
//   index_enable    gates quad_I
//   quad_A, quad_B  registered encoder phases
//   quad_I          index pulse: index_enable & (rev_pos == 0)
//   busy            high while a move is in progress (LOAD/WAIT/STEP)
//   done            one-cycle pulse on completion of a command
//   position        signed running edge count, wraps at POS_WIDTH
// -----------------------------------------------------------------------------
module qe_signal_emulator #(
  parameter int COUNTS_PER_REV = 2048,
  parameter int POS_WIDTH      = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [31:0]                 cmd_steps,
  input  logic [31:0]                 cmd_phase_time,
  input  logic                        abort,
  input  logic                        index_enable,
  output logic                        quad_A,
  output logic                        quad_B,
  output logic                        quad_I,
  output logic                        busy,
  output logic                        done,
  output logic signed [POS_WIDTH-1:0] position
);

  localparam int REV_W = (COUNTS_PER_REV > 1) ? $clog2(COUNTS_PER_REV) : 1;
  localparam logic [REV_W-1:0] REV_MAX = REV_W'(COUNTS_PER_REV - 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] STEP = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]       state;
  logic [31:0]      remaining;   // unsigned: |-2^31| = 2^31 fits
  logic             dir_ccw;
  logic [31:0]      period;
  logic [31:0]      timer;
  logic [REV_W-1:0] rev_pos;

  // Magnitude of the signed command; two's-complement negate of -2^31 yields
  // 2^31, which is exactly the unsigned magnitude wanted.
  logic [31:0] steps_abs;
  assign steps_abs = cmd_steps[31] ? (~cmd_steps + 32'd1) : cmd_steps;

  assign cmd_ready = (state == IDLE) && !abort;
  assign busy      = (state == LOAD) || (state == WAIT) || (state == STEP);
  assign done      = (state == DONE);
  assign quad_I    = index_enable && (rev_pos == '0);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      dir_ccw   <= 1'b0;
      period    <= 32'd1;
      timer     <= '0;
      rev_pos   <= '0;
      position  <= '0;
      quad_A    <= 1'b0;
      quad_B    <= 1'b0;
    end else if (abort && (state != IDLE)) begin
      // Outputs and position hold; any edge due this cycle is dropped.
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            remaining <= steps_abs;
            dir_ccw   <= cmd_steps[31];
            period    <= (cmd_phase_time == 32'd0) ? 32'd1 : cmd_phase_time;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (remaining == 32'd0) begin
            state <= DONE;
          end else begin
            timer <= period - 32'd1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (timer == 32'd0) begin
            // The edge is launched on entry to STEP so it is visible while in
            // STEP; this gives period+1 clocks from accept to the first edge
            // and between consecutive edges.
            remaining <= remaining - 32'd1;
            if (dir_ccw) begin
              // CCW walks 00 -> 01 -> 11 -> 10 -> 00.
              quad_A   <= quad_B;
              quad_B   <= ~quad_A;
              position <= position - POS_WIDTH'(1);
              rev_pos  <= (rev_pos == '0) ? REV_MAX : rev_pos - REV_W'(1);
            end else begin
              // CW walks 00 -> 10 -> 11 -> 01 -> 00.
              quad_A   <= ~quad_B;
              quad_B   <= quad_A;
              position <= position + POS_WIDTH'(1);
              rev_pos  <= (rev_pos == REV_MAX) ? '0 : rev_pos + REV_W'(1);
            end
            state <= STEP;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        STEP: begin
          if (remaining == 32'd0) begin
            state <= DONE;
          end else begin
            timer <= period - 32'd1;
            state <= WAIT;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qe_signal_emulator.sv
// -----------------------------------------------------------------------------
// tb_qe_signal_emulator
//
// Directed bench for qe_signal_emulator built with a 4-count revolution so the
// index wrap is reachable in a short move. A small reference model tracks the
// expected phase, position and revolution position; every cycle of a move is
// compared against it.
// -----------------------------------------------------------------------------
module tb_qe_signal_emulator;

  localparam int CPR = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_steps;
  logic [31:0] cmd_phase_time;
  logic        abort;
  logic        index_enable;
  logic        quad_A;
  logic        quad_B;
  logic        quad_I;
  logic        busy;
  logic        done;
  logic signed [31:0] position;

  qe_signal_emulator #(
    .COUNTS_PER_REV(CPR),
    .POS_WIDTH     (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_steps     (cmd_steps),
    .cmd_phase_time(cmd_phase_time),
    .abort         (abort),
    .index_enable  (index_enable),
    .quad_A        (quad_A),
    .quad_B        (quad_B),
    .quad_I        (quad_I),
    .busy          (busy),
    .done          (done),
    .position      (position)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: (A,B) sequence in CW order, indexed by phase.
  logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int m_idx, m_pos, m_rev;

  function automatic void model_reset();
    m_idx = 0;
    m_pos = 0;
    m_rev = 0;
  endfunction

  function automatic void model_edge(input bit cw);
    if (cw) begin
      m_idx = (m_idx + 1) % 4;
      m_pos = m_pos + 1;
      m_rev = (m_rev + 1) % CPR;
    end else begin
      m_idx = (m_idx + 3) % 4;
      m_pos = m_pos - 1;
      m_rev = (m_rev + CPR - 1) % CPR;
    end
  endfunction

  function automatic logic [31:0] exp_index();
    return {31'd0, index_enable && (m_rev == 0)};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, ":ab"},    {30'd0, quad_A, quad_B}, {30'd0, seq[m_idx]});
    check({tag, ":pos"},   position, 32'(m_pos));
    check({tag, ":busy"},  {31'd0, busy}, 32'd0);
    check({tag, ":done"},  {31'd0, done}, 32'd0);
    check({tag, ":ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, ":idx"},   {31'd0, quad_I}, exp_index());
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    #1 check_idle_outputs(tag);
    reset = 1'b0;
  endtask

  // Issue one command and follow it cycle by cycle. Cycle 0 is the first
  // sample after the accept edge; edge i appears at cycle i*(p+1) and done at
  // the cycle after the last edge. A junk command is held on cmd_valid during
  // the move to show it is ignored. abort_at>0 aborts the cycle before that
  // edge would appear.
  task automatic move(input string tag, input int steps, input int pt, input int abort_at);
    int p, n, end_cyc, edges;
    bit cw;
    p       = (pt == 0) ? 1 : pt;
    n       = (steps < 0) ? -steps : steps;
    cw      = (steps >= 0);
    end_cyc = (n == 0) ? 1 : n * (p + 1) + 1;
    edges   = 0;

    @(negedge clk);
    cmd_valid      = 1'b1;
    cmd_steps      = steps;
    cmd_phase_time = pt;
    #1 check({tag, ":accept_ready"}, {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_steps      = -32'sd7;
    cmd_phase_time = 32'd2;

    for (int cyc = 0; cyc <= end_cyc; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (n > 0 && cyc > 0 && (cyc % (p + 1)) == 0 && edges < n) begin
        model_edge(cw);
        edges++;
        check({tag, ":pos"}, position, 32'(m_pos));
      end
      check({tag, ":ab"},    {30'd0, quad_A, quad_B}, {30'd0, seq[m_idx]});
      check({tag, ":idx"},   {31'd0, quad_I}, exp_index());
      check({tag, ":busy"},  {31'd0, busy}, {31'd0, cyc < end_cyc});
      check({tag, ":done"},  {31'd0, done}, {31'd0, cyc == end_cyc});
      check({tag, ":ready"}, {31'd0, cmd_ready}, 32'd0);
      if (cyc == end_cyc) cmd_valid = 1'b0;
      if (abort_at > 0 && edges == abort_at - 1 && cyc == abort_at * (p + 1) - 1) begin
        abort     = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        #1 check_idle_outputs({tag, ":abort"});
        return;
      end
    end

    @(negedge clk);
    #1 check_idle_outputs({tag, ":after"});
  endtask

  initial begin
    reset          = 1'b1;
    cmd_valid      = 1'b0;
    cmd_steps      = '0;
    cmd_phase_time = '0;
    abort          = 1'b0;
    index_enable   = 1'b0;
    model_reset();

    // Reset state, then index_enable alone drives quad_I at rev_pos 0.
    do_reset("reset");
    index_enable = 1'b1;
    #1 check("reset:idx_en", {31'd0, quad_I}, 32'd1);
    index_enable = 1'b0;

    // 1: eight CW edges, period 3 -> an edge every 4 clocks, position 8.
    move("t1", 8, 3, 0);
    check("t1:final_pos", position, 32'd8);

    // 2: five CCW edges, phase_time 1, continuing from 00 -> position 3.
    move("t2", -5, 1, 0);
    check("t2:final_pos", position, 32'd3);
    check("t2:final_ab", {30'd0, quad_A, quad_B}, 32'd1);

    // 3: index pulses at rev_pos 0 (start, after edges 4 and 8); phase_time 0.
    do_reset("t3_reset");
    index_enable = 1'b1;
    move("t3", 9, 0, 0);
    check("t3:final_idx", {31'd0, quad_I}, 32'd0);

    // 4: zero-step command -> no phase change, done on the clock after LOAD.
    move("t4", 0, 5, 0);

    // 5: abort in the cycle edge 10 is due -> nine edges, no done.
    do_reset("t5_reset");
    move("t5", 100, 1, 10);
    check("t5:final_pos", position, 32'd9);
    check("t5:final_ab", {30'd0, quad_A, quad_B}, 32'h2);

    // 6: reset in the middle of a move, then a fresh move from phase 00.
    @(negedge clk);
    cmd_valid      = 1'b1;
    cmd_steps      = 32'd50;
    cmd_phase_time = 32'd2;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("t6:moving", {31'd0, busy}, 32'd1);
    do_reset("t6_reset");
    move("t6b", 2, 0, 0);
    check("t6b:final_ab", {30'd0, quad_A, quad_B}, 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
